// File: rtl/gpio_pin_arbiter_pkg.sv
// Shared encodings for the GPIO pin arbiter and the pin mux it steers.
// Select codes match the requester bit index; state codes are shared for debug visibility.
package gpio_pin_arbiter_pkg;

    localparam logic [1:0] SEL_UART0_TX = 2'd0;
    localparam logic [1:0] SEL_UART0_RX = 2'd1;
    localparam logic [1:0] SEL_PWM1     = 2'd2;
    localparam logic [1:0] SEL_OTHER    = 2'd3;

    localparam int unsigned NUM_REQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_OWNED = 2'd2
    } arb_state_e;

    function automatic logic [NUM_REQ-1:0] sel_onehot(input logic [1:0] s);
        return 4'b0001 << s;
    endfunction

endpackage

// File: rtl/gpio_rr_pick.sv
// Combinational round-robin pick: first set request scanning from last_owner+1 (mod 4).
// Zero latency; no handshake, any=0 when nothing is requested.
module gpio_rr_pick
    import gpio_pin_arbiter_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last_owner,
    output logic [1:0] winner,
    output logic       any
);

    logic [1:0] idx;

    always_comb begin
        winner = last_owner;
        any    = 1'b0;
        idx    = 2'b00;
        // k=4 wraps back to last_owner, so a lone repeat requester still wins
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = last_owner + 2'(k);
            if (!any && req[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpio_pin_arbiter.sv
// Hands one GPIO pin to one of four peripherals, with a driver-off guard window between owners.
// Grant rises GUARD_CYCLES+1 edges after the request is first seen; long holders yield after MAX_HOLD.
module gpio_pin_arbiter
    import gpio_pin_arbiter_pkg::*;
#(
    parameter int unsigned GUARD_CYCLES = 4,
    parameter int unsigned MAX_HOLD     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [1:0] sel,
    output logic       pin_en,
    output logic [3:0] gnt,
    output logic       busy
);

    arb_state_e  state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [1:0]  last_owner_q, last_owner_d;
    logic [7:0]  guard_cnt_q, guard_cnt_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic        pin_en_q, pin_en_d;
    logic [3:0]  gnt_q, gnt_d;
    logic        busy_q, busy_d;

    logic [1:0]  rr_winner;
    logic        rr_any;
    logic        owner_req;
    logic        others_pending;
    logic        guard_done;
    logic        hold_expired;

    gpio_rr_pick u_rr_pick (
        .req        (req),
        .last_owner (last_owner_q),
        .winner     (rr_winner),
        .any        (rr_any)
    );

    assign owner_req      = req[sel_q];
    assign others_pending = |(req & ~sel_onehot(sel_q));
    assign guard_done     = (guard_cnt_q == 8'(GUARD_CYCLES - 1));
    assign hold_expired   = (hold_cnt_q == 16'(MAX_HOLD));

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_owner_d = last_owner_q;
        guard_cnt_d  = guard_cnt_q;
        hold_cnt_d   = hold_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (rr_any) begin
                    sel_d       = rr_winner;
                    guard_cnt_d = 8'd0;
                    state_d     = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (!owner_req) begin
                    state_d = ST_IDLE;
                end else if (guard_done) begin
                    state_d      = ST_OWNED;
                    last_owner_d = sel_q;
                    hold_cnt_d   = 16'd0;
                end else begin
                    guard_cnt_d = guard_cnt_q + 8'd1;
                end
            end
            ST_OWNED: begin
                // Release always goes through IDLE so the guard window is never skipped
                if (!owner_req || (hold_expired && others_pending)) begin
                    state_d = ST_IDLE;
                end else if (!hold_expired) begin
                    hold_cnt_d = hold_cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        pin_en_d = (state_d == ST_OWNED);
        gnt_d    = pin_en_d ? sel_onehot(sel_d) : 4'b0000;
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sel_q        <= SEL_UART0_TX;
            last_owner_q <= SEL_OTHER;
            guard_cnt_q  <= 8'd0;
            hold_cnt_q   <= 16'd0;
            pin_en_q     <= 1'b0;
            gnt_q        <= 4'b0000;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_owner_q <= last_owner_d;
            guard_cnt_q  <= guard_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            pin_en_q     <= pin_en_d;
            gnt_q        <= gnt_d;
            busy_q       <= busy_d;
        end
    end

    assign sel    = sel_q;
    assign pin_en = pin_en_q;
    assign gnt    = gnt_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_gpio_pin_arbiter.sv
// Bench for gpio_pin_arbiter: directed scenarios plus random traffic against a cycle-level model.
module tb_gpio_pin_arbiter;

    localparam int G = 4;
    localparam int H = 8;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [1:0] sel;
    logic       pin_en;
    logic [3:0] gnt;
    logic       busy;

    int n_pass  = 0;
    int n_total = 0;

    // model: mode 0 idle, 1 guard, 2 owned; cnt = cycles spent in the current phase
    int m_mode = 0;
    int m_cnt  = 0;
    int m_sel  = 0;
    int m_last = 3;

    logic       mon_on      = 1'b0;
    logic       prev_pin_en = 1'b0;
    logic [1:0] prev_sel    = 2'b00;

    gpio_pin_arbiter #(.GUARD_CYCLES(G), .MAX_HOLD(H)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .sel    (sel),
        .pin_en (pin_en),
        .gnt    (gnt),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_step(input logic [3:0] r, input logic rs);
        logic [3:0] own;
        logic       found;
        own = 4'b0001 << m_sel;
        if (rs) begin
            m_mode = 0; m_cnt = 0; m_sel = 0; m_last = 3;
        end else begin
            case (m_mode)
                0: if (r != 4'b0000) begin
                    found = 1'b0;
                    for (int k = 1; k <= 4; k++) begin
                        if (!found && r[(m_last + k) % 4]) begin
                            m_sel = (m_last + k) % 4;
                            found = 1'b1;
                        end
                    end
                    m_mode = 1; m_cnt = 1;
                end
                1: if (!r[m_sel]) m_mode = 0;
                   else if (m_cnt == G) begin m_mode = 2; m_last = m_sel; m_cnt = 0; end
                   else m_cnt++;
                2: if (!r[m_sel]) m_mode = 0;
                   else if (m_cnt >= H && (r & ~own) != 4'b0000) m_mode = 0;
                   else m_cnt++;
                default: m_mode = 0;
            endcase
        end
    endfunction

    function automatic logic [7:0] exp_vec();
        logic [3:0] g;
        logic [1:0] s;
        g = (m_mode == 2) ? (4'b0001 << m_sel) : 4'b0000;
        s = 2'(m_sel);
        return {s, (m_mode == 2), g, (m_mode != 0)};
    endfunction

    task automatic tick(input logic [3:0] r, input logic rs);
        req = r;
        rst = rs;
        @(posedge clk);
        model_step(r, rs);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            n_total++;
            if (!$onehot0(gnt) || ((gnt != 4'b0000) != pin_en) || (pin_en && prev_pin_en && sel !== prev_sel))
                $display("FAIL invariant t=%0t: sel %b pin_en %b gnt %b prev_sel %b, want one-hot-or-zero gnt tracking pin_en and stable sel",
                         $time, sel, pin_en, gnt, prev_sel);
            else n_pass++;
            prev_pin_en = pin_en;
            prev_sel    = sel;
        end
    end

    task automatic test_reset();
        tick(4'b1111, 1'b1);
        tick(4'b1111, 1'b1);
        n_total++;
        if ({sel, pin_en, gnt, busy} !== 8'b0)
            $display("FAIL reset_state: got %b want %b", {sel, pin_en, gnt, busy}, 8'b0);
        else n_pass++;
        tick(4'b0000, 1'b0);
        n_total++;
        if ({sel, pin_en, gnt, busy} !== exp_vec())
            $display("FAIL reset_idle: got %b want %b", {sel, pin_en, gnt, busy}, exp_vec());
        else n_pass++;
        mon_on = 1'b1;
    endtask

    task automatic test_single_grant();
        int rise_edge;
        rise_edge = -1;
        tick(4'b0000, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            tick(4'b0100, 1'b0);
            n_total++;
            if ({sel, pin_en, gnt, busy} !== exp_vec())
                $display("FAIL single_model edge %0d: got %b want %b", i, {sel, pin_en, gnt, busy}, exp_vec());
            else n_pass++;
            if (i == 1) begin
                n_total++;
                if (sel !== 2'b10 || busy !== 1'b1 || pin_en !== 1'b0)
                    $display("FAIL single_edge1: got sel %b busy %b pin_en %b want 10 1 0", sel, busy, pin_en);
                else n_pass++;
            end
            if (rise_edge < 0 && pin_en === 1'b1) rise_edge = i;
        end
        n_total++;
        if (rise_edge !== G + 1 || gnt !== 4'b0100)
            $display("FAIL single_latency: got edge %0d gnt %b want edge %0d gnt 0100", rise_edge, gnt, G + 1);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int   order[$];
        int   exp_order[5];
        int   gap;
        logic was;
        exp_order = '{0, 1, 2, 3, 0};
        gap = 0;
        was = 1'b0;
        tick(4'b0000, 1'b1);
        for (int i = 0; i < 66; i++) begin
            tick(4'b1111, 1'b0);
            n_total++;
            if ({sel, pin_en, gnt, busy} !== exp_vec())
                $display("FAIL rr_model cyc %0d: got %b want %b", i, {sel, pin_en, gnt, busy}, exp_vec());
            else n_pass++;
            if (pin_en === 1'b1 && !was) begin
                order.push_back(int'(sel));
                if (order.size() > 1) begin
                    n_total++;
                    if (gap != G + 1)
                        $display("FAIL rr_gap grant %0d: got %0d dead cycles want %0d", order.size(), gap, G + 1);
                    else n_pass++;
                end
                gap = 0;
            end else if (pin_en !== 1'b1) begin
                gap++;
            end
            was = pin_en;
        end
        n_total++;
        if (order.size() != 5)
            $display("FAIL rr_count: got %0d grants want 5", order.size());
        else n_pass++;
        for (int j = 0; j < 5 && j < order.size(); j++) begin
            n_total++;
            if (order[j] != exp_order[j])
                $display("FAIL rr_order[%0d]: got %0d want %0d", j, order[j], exp_order[j]);
            else n_pass++;
        end
    endtask

    task automatic test_abort();
        logic saw_g0;
        saw_g0 = 1'b0;
        tick(4'b0000, 1'b1);
        tick(4'b0001, 1'b0);
        tick(4'b0001, 1'b0);
        tick(4'b0000, 1'b0);
        n_total++;
        if (busy !== 1'b0 || gnt !== 4'b0000 || pin_en !== 1'b0)
            $display("FAIL abort_idle: got busy %b gnt %b pin_en %b want 0 0000 0", busy, gnt, pin_en);
        else n_pass++;
        for (int i = 0; i < G + 1; i++) begin
            tick(4'b0010, 1'b0);
            if (gnt[0] === 1'b1) saw_g0 = 1'b1;
            n_total++;
            if ({sel, pin_en, gnt, busy} !== exp_vec())
                $display("FAIL abort_model cyc %0d: got %b want %b", i, {sel, pin_en, gnt, busy}, exp_vec());
            else n_pass++;
        end
        n_total++;
        if (saw_g0 || gnt !== 4'b0010)
            $display("FAIL abort_next: got gnt %b (saw gnt0 %b) want 0010 and no gnt0", gnt, saw_g0);
        else n_pass++;
    endtask

    task automatic test_sole_owner();
        int breaks;
        breaks = 0;
        tick(4'b0000, 1'b1);
        for (int i = 1; i <= 55; i++) begin
            tick(4'b1000, 1'b0);
            if (i >= G + 1 && gnt !== 4'b1000) breaks++;
        end
        n_total++;
        if (breaks != 0 || gnt !== 4'b1000)
            $display("FAIL sole_hold: got %0d dropped cycles, gnt %b want 0 and 1000", breaks, gnt);
        else n_pass++;
        tick(4'b1001, 1'b0);
        n_total++;
        if (pin_en !== 1'b0 || gnt !== 4'b0000)
            $display("FAIL sole_preempt: got pin_en %b gnt %b want 0 0000", pin_en, gnt);
        else n_pass++;
        for (int i = 0; i < G + 1; i++) tick(4'b1001, 1'b0);
        n_total++;
        if (gnt !== 4'b0001 || {sel, pin_en, gnt, busy} !== exp_vec())
            $display("FAIL sole_next: got %b want %b with gnt 0001", {sel, pin_en, gnt, busy}, exp_vec());
        else n_pass++;
    endtask

    task automatic test_reset_mid_owned();
        tick(4'b0000, 1'b1);
        for (int i = 0; i < G + 3; i++) tick(4'b0010, 1'b0);
        n_total++;
        if (gnt !== 4'b0010)
            $display("FAIL rstmid_owned: got gnt %b want 0010", gnt);
        else n_pass++;
        tick(4'b0011, 1'b1);
        n_total++;
        if (pin_en !== 1'b0 || gnt !== 4'b0000 || sel !== 2'b00 || busy !== 1'b0)
            $display("FAIL rstmid_clear: got sel %b pin_en %b gnt %b busy %b want 00 0 0000 0", sel, pin_en, gnt, busy);
        else n_pass++;
        for (int i = 0; i < G + 1; i++) tick(4'b0011, 1'b0);
        n_total++;
        if (gnt !== 4'b0001)
            $display("FAIL rstmid_winner: got gnt %b want 0001", gnt);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic       rs;
        r = 4'b0000;
        tick(4'b0000, 1'b1);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) r = 4'($urandom_range(0, 15));
            rs = ($urandom_range(0, 99) == 0);
            tick(r, rs);
            n_total++;
            if ({sel, pin_en, gnt, busy} !== exp_vec())
                $display("FAIL random cyc %0d req %b rst %b: got %b want %b", i, r, rs, {sel, pin_en, gnt, busy}, exp_vec());
            else n_pass++;
        end
    endtask

    initial begin
        req = 4'b0000;
        rst = 1'b1;
        test_reset();
        test_single_grant();
        test_round_robin();
        test_abort();
        test_sole_owner();
        test_reset_mid_owned();
        test_random();
        mon_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
